// File: rtl/full_adder_sync_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_sync_pkg;

    // Default operand/sum width of the datapath adder.
    localparam int ADDER_WIDTH = 8;

    // Cycles from operand capture to result visibility.
    localparam int ADDER_LATENCY = 1;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the unit of the ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder_sync.sv
// Unsigned adder {cy_o,y_o} = a_i + b_i + cy_i built as a ripple chain of
// full_adder_bit cells, followed by one output register stage.
module full_adder_sync
    import full_adder_sync_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cy_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] y_o,
    output logic             cy_o
);

    // carry[i] enters cell i; carry[WIDTH] is the carry-out of the chain.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] y_q;
    logic             cy_q;
    logic             vld_q;

    assign carry[0] = cy_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a  (a_i[i]),
            .b  (b_i[i]),
            .c  (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Result register: capture only on valid so idle operands never disturb it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y_q  <= '0;
            cy_q <= 1'b0;
        end else if (valid_i) begin
            y_q  <= sum;
            cy_q <= carry[WIDTH];
        end
    end

    // Valid flag follows valid_i by one cycle, giving one result per cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) vld_q <= 1'b0;
        else          vld_q <= valid_i;
    end

    assign y_o     = y_q;
    assign cy_o    = cy_q;
    assign valid_o = vld_q;

endmodule

// File: tb/tb_full_adder_sync.sv
// Scoreboard bench for full_adder_sync: the driver pushes expected results,
// a negedge monitor pops and compares whenever valid_o is high and checks
// that outputs hold while valid_o is low.
module tb_full_adder_sync;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] y;
        logic         cy;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cy_i = 1'b0;
    logic         valid_o;
    logic [W-1:0] y_o;
    logic         cy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    full_adder_sync #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cy_i    (cy_i),
        .valid_o (valid_o),
        .y_o     (y_o),
        .cy_o    (cy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of stimulus; on valid, queue the hand-supplied result.
    task automatic issue(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] ey, input logic ecy);
        exp_t e;
        @(posedge clk);
        #1;
        valid_i = v;
        a_i = a;
        b_i = b;
        cy_i = c;
        if (v) begin
            e.y = ey;
            e.cy = ecy;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    // Monitor: compare popped results, and check hold behaviour when idle.
    logic [W-1:0] held_y = '0;
    logic         held_cy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_y = '0;
            held_cy = 1'b0;
        end else if (valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(y_o), 32'(e.y));
                check("carry", 32'(cy_o), 32'(e.cy));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
                held_y = e.y;
                held_cy = e.cy;
            end
        end else begin
            check("hold_sum", 32'(y_o), 32'(held_y));
            check("hold_carry", 32'(cy_o), 32'(held_cy));
        end
    end

    // Directed vectors: a, b, cy, expected y, expected cy (hand computed).
    logic [W-1:0] va [7] = '{8'd0,   8'd1, 8'd0,   8'd255, 8'd255, 8'd100, 8'd100};
    logic [W-1:0] vb [7] = '{8'd0,   8'd1, 8'd255, 8'd255, 8'd0,   8'd155, 8'd155};
    logic         vc [7] = '{1'b0,   1'b1, 1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
    logic [W-1:0] vy [7] = '{8'd0,   8'd3, 8'd255, 8'd255, 8'd0,   8'd0,   8'd255};
    logic         vk [7] = '{1'b0,   1'b0, 1'b0,   1'b1,   1'b1,   1'b1,   1'b0};

    initial begin
        logic [W:0]   ref_sum;
        logic [W-1:0] ra, rb;
        logic         rc, rv;

        // Reset state while held in reset.
        #1;
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_sum", 32'(y_o), 32'd0);
        check("reset_carry", 32'(cy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, issued back-to-back (streaming).
        for (int i = 0; i < 7; i++) issue(1'b1, va[i], vb[i], vc[i], vy[i], vk[i]);

        // Idle with junk operands: outputs must hold.
        for (int i = 0; i < 3; i++)
            issue(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), '0, 1'b0);

        // Mid-run reset: the in-flight 1+1+1 is discarded.
        issue(1'b1, 8'd1, 8'd1, 1'b1, 8'd3, 1'b0);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_valid", 32'(valid_o), 32'd0);
        check("midreset_sum", 32'(y_o), 32'd0);
        check("midreset_carry", 32'(cy_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        valid_i = 1'b0;
        issue(1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        issue(1'b0, 8'd77, 8'd12, 1'b1, '0, 1'b0);

        // Random regression against a 9-bit reference sum.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            issue(rv, ra, rb, rc, ref_sum[W-1:0], ref_sum[W]);
        end

        // Drain and confirm every queued result was produced.
        for (int i = 0; i < 3; i++) issue(1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
